simon_sequencer: RTL and testbench

Parametrised game engine for the tile memory game. It generates, stores, plays back and checks a growing tile sequence for up to NUM_TILES tiles and MAX_LEN rounds. It sits between the tile-graphics path, which consumes show_tile/show_on, and the key/player input path. It also tracks the current and best scores, with an optional input timeout.

---
 rtl/simon_sequencer.sv | 189 ++++++++++++++++++
 tb/tb_simon_sequencer.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/simon_sequencer.sv
// Tile memory game engine: grows a random tile sequence, plays it back as
// timed flashes, checks the player's echo and keeps current/best scores.
module simon_sequencer #(
    parameter int          NUM_TILES      = 4,
    parameter int          TILE_W         = 2,
    parameter int          MAX_LEN        = 16,
    parameter int          LEN_W          = 5,
    parameter int          FLASH_CYCLES   = 25000000,
    parameter int          GAP_CYCLES     = 12500000,
    parameter int          TIMEOUT_CYCLES = 0,
    parameter logic [15:0] SEED           = 16'hACE1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic              key_valid,
    input  logic [TILE_W-1:0] key_tile,
    output logic              show_on,
    output logic [TILE_W-1:0] show_tile,
    output logic              await_input,
    output logic [LEN_W-1:0]  score,
    output logic [LEN_W-1:0]  best_score,
    output logic              game_over,
    output logic              win
);

    localparam int TMR_MAX = (FLASH_CYCLES > GAP_CYCLES) ? FLASH_CYCLES : GAP_CYCLES;
    localparam int TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;
    localparam int TO_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int IDX_W   = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

    localparam logic [TMR_W-1:0] GAP_LOAD   = TMR_W'(GAP_CYCLES - 1);
    localparam logic [TMR_W-1:0] FLASH_LOAD = TMR_W'(FLASH_CYCLES - 1);
    localparam logic [TO_W-1:0]  TO_LOAD    = (TIMEOUT_CYCLES > 0) ? TO_W'(TIMEOUT_CYCLES - 1) : '0;

    typedef enum logic [2:0] {
        IDLE, APPEND, SHOW_GAP, SHOW_ON, WAIT_KEY, LOSE, WIN
    } state_t;

    state_t              state, state_n;
    logic [LEN_W-1:0]    len, len_n;
    logic [LEN_W-1:0]    idx, idx_n;
    logic [TMR_W-1:0]    timer, timer_n;
    logic [TO_W-1:0]     tcnt, tcnt_n;
    logic [15:0]         lfsr;
    logic [TILE_W-1:0]   mem [MAX_LEN];
    logic                mem_we;
    logic [TILE_W-1:0]   new_tile;
    logic                key_ok;

    logic                show_on_n, await_n, go_n, win_n;
    logic [TILE_W-1:0]   show_tile_n;
    logic [LEN_W-1:0]    score_n, best_n;

    assign new_tile = TILE_W'(lfsr[7:0] % 8'(NUM_TILES));
    assign key_ok   = ({1'b0, key_tile} < (TILE_W+1)'(NUM_TILES)) &&
                      (key_tile == mem[idx[IDX_W-1:0]]);

    always_comb begin
        state_n     = state;
        len_n       = len;
        idx_n       = idx;
        timer_n     = timer;
        tcnt_n      = tcnt;
        show_on_n   = show_on;
        show_tile_n = show_tile;
        await_n     = await_input;
        score_n     = score;
        best_n      = best_score;
        go_n        = game_over;
        win_n       = win;
        mem_we      = 1'b0;

        case (state)
            IDLE, LOSE, WIN: begin
                if (start) begin
                    len_n   = '0;
                    score_n = '0;
                    go_n    = 1'b0;
                    win_n   = 1'b0;
                    state_n = APPEND;
                end
            end
            APPEND: begin
                mem_we  = 1'b1;
                len_n   = len + LEN_W'(1);
                idx_n   = '0;
                timer_n = GAP_LOAD;
                state_n = SHOW_GAP;
            end
            SHOW_GAP: begin
                if (timer == '0) begin
                    if (idx < len) begin
                        show_tile_n = mem[idx[IDX_W-1:0]];
                        show_on_n   = 1'b1;
                        timer_n     = FLASH_LOAD;
                        state_n     = SHOW_ON;
                    end else begin
                        idx_n   = '0;
                        tcnt_n  = TO_LOAD;
                        await_n = 1'b1;
                        state_n = WAIT_KEY;
                    end
                end else begin
                    timer_n = timer - TMR_W'(1);
                end
            end
            SHOW_ON: begin
                if (timer == '0) begin
                    idx_n     = idx + LEN_W'(1);
                    timer_n   = GAP_LOAD;
                    show_on_n = 1'b0;
                    state_n   = SHOW_GAP;
                end else begin
                    timer_n = timer - TMR_W'(1);
                end
            end
            WAIT_KEY: begin
                if (key_valid) begin
                    if (!key_ok) begin
                        go_n    = 1'b1;
                        await_n = 1'b0;
                        state_n = LOSE;
                    end else if ((idx + LEN_W'(1)) == len) begin
                        score_n = len;
                        if (len > best_score) best_n = len;
                        await_n = 1'b0;
                        if (len == LEN_W'(MAX_LEN)) begin
                            win_n   = 1'b1;
                            state_n = WIN;
                        end else begin
                            state_n = APPEND;
                        end
                    end else begin
                        idx_n  = idx + LEN_W'(1);
                        tcnt_n = TO_LOAD;
                    end
                end else if (TIMEOUT_CYCLES > 0) begin
                    // Timeout expiry behaves exactly like a wrong key.
                    if (tcnt == '0) begin
                        go_n    = 1'b1;
                        await_n = 1'b0;
                        state_n = LOSE;
                    end else begin
                        tcnt_n = tcnt - TO_W'(1);
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= IDLE;
            len         <= '0;
            idx         <= '0;
            timer       <= '0;
            tcnt        <= '0;
            lfsr        <= SEED;
            show_on     <= 1'b0;
            show_tile   <= '0;
            await_input <= 1'b0;
            score       <= '0;
            best_score  <= '0;
            game_over   <= 1'b0;
            win         <= 1'b0;
        end else begin
            state       <= state_n;
            len         <= len_n;
            idx         <= idx_n;
            timer       <= timer_n;
            tcnt        <= tcnt_n;
            lfsr        <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
            show_on     <= show_on_n;
            show_tile   <= show_tile_n;
            await_input <= await_n;
            score       <= score_n;
            best_score  <= best_n;
            game_over   <= go_n;
            win         <= win_n;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset && mem_we) mem[len[IDX_W-1:0]] <= new_tile;
    end

endmodule

// File: tb/tb_simon_sequencer.sv
// Directed bench for simon_sequencer: vector table for reset and the first
// playback, then hand-written game sequences on a plain and a timeout instance.
module tb_simon_sequencer;

    localparam logic [15:0] SEED = 16'hACE1;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       start_a = 1'b0, key_valid_a = 1'b0;
    logic [1:0] key_tile_a = '0;
    logic       start_b = 1'b0, key_valid_b = 1'b0;
    logic [1:0] key_tile_b = '0;

    logic       show_on_a, await_a, go_a, win_a;
    logic [1:0] show_tile_a;
    logic [2:0] score_a, best_a;
    logic       show_on_b, await_b, go_b, win_b;
    logic [1:0] show_tile_b;
    logic [2:0] score_b, best_b;

    always #5 clock = ~clock;

    simon_sequencer #(
        .NUM_TILES(4), .TILE_W(2), .MAX_LEN(4), .LEN_W(3),
        .FLASH_CYCLES(3), .GAP_CYCLES(2), .TIMEOUT_CYCLES(0), .SEED(SEED)
    ) dut_a (
        .clock(clock), .reset(reset), .start(start_a),
        .key_valid(key_valid_a), .key_tile(key_tile_a),
        .show_on(show_on_a), .show_tile(show_tile_a), .await_input(await_a),
        .score(score_a), .best_score(best_a), .game_over(go_a), .win(win_a)
    );

    simon_sequencer #(
        .NUM_TILES(4), .TILE_W(2), .MAX_LEN(4), .LEN_W(3),
        .FLASH_CYCLES(3), .GAP_CYCLES(2), .TIMEOUT_CYCLES(10), .SEED(SEED)
    ) dut_b (
        .clock(clock), .reset(reset), .start(start_b),
        .key_valid(key_valid_b), .key_tile(key_tile_b),
        .show_on(show_on_b), .show_tile(show_tile_b), .await_input(await_b),
        .score(score_b), .best_score(best_b), .game_over(go_b), .win(win_b)
    );

    // Reference LFSR: both instances share reset, so one model serves both.
    logic [15:0] m_lfsr;
    always @(posedge clock) begin
        if (reset) m_lfsr <= SEED;
        else       m_lfsr <= {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
    end

    logic       dsel = 1'b0;
    logic       o_so, o_aw, o_go, o_win;
    logic [1:0] o_tile;
    logic [2:0] o_score, o_best;
    always_comb begin
        o_so    = dsel ? show_on_b   : show_on_a;
        o_tile  = dsel ? show_tile_b : show_tile_a;
        o_aw    = dsel ? await_b     : await_a;
        o_score = dsel ? score_b     : score_a;
        o_best  = dsel ? best_b      : best_a;
        o_go    = dsel ? go_b        : go_a;
        o_win   = dsel ? win_b       : win_a;
    end

    int checks = 0;
    int errors = 0;
    logic [1:0] exp_seq [4];
    int exp_best = 0;

    typedef struct {
        logic       rst, st, kv;
        logic [1:0] kt;
        logic       so, ctile;
        logic [1:0] tile;
        logic       aw;
    } vec_t;
    vec_t vt [11];

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    function automatic logic [1:0] model_tile();
        return 2'(m_lfsr[7:0] % 8'd4);
    endfunction

    task automatic press(input logic [1:0] t);
        if (dsel) begin key_valid_b = 1'b1; key_tile_b = t; end
        else      begin key_valid_a = 1'b1; key_tile_a = t; end
        tick();
        key_valid_a = 1'b0;
        key_valid_b = 1'b0;
    endtask

    // Offsets counted from the deciding edge (start or final correct key).
    task automatic check_playback(input int n);
        int len_cyc;
        len_cyc = 1 + n * 5 + 2;
        for (int k = 1; k <= len_cyc; k++) begin
            int  j;
            bit  exp_so;
            tick();
            j      = (k >= 3) ? (k - 3) / 5 : 0;
            exp_so = (k >= 3) && (((k - 3) % 5) < 3) && (j < n);
            chk($sformatf("pb%0d_k%0d_show_on", n, k), int'(o_so), int'(exp_so));
            chk($sformatf("pb%0d_k%0d_await", n, k), int'(o_aw), (k == len_cyc) ? 1 : 0);
            if (exp_so)
                chk($sformatf("pb%0d_k%0d_tile", n, k), int'(o_tile), int'(exp_seq[j]));
        end
    endtask

    task automatic echo_round(input int n, input int pre, input bit start_on_last);
        for (int j = 0; j < n; j++) begin
            for (int p = 0; p < pre; p++) tick();
            if (j == n - 1 && start_on_last) begin
                if (dsel) start_b = 1'b1; else start_a = 1'b1;
            end
            press(exp_seq[j]);
            start_a = 1'b0;
            start_b = 1'b0;
            if (j < n - 1) begin
                chk($sformatf("r%0d_key%0d_await", n, j), int'(o_aw), 1);
                chk($sformatf("r%0d_key%0d_go", n, j), int'(o_go), 0);
            end else begin
                if (n > exp_best) exp_best = n;
                chk($sformatf("r%0d_done_await", n), int'(o_aw), 0);
                chk($sformatf("r%0d_done_score", n), int'(o_score), n);
                chk($sformatf("r%0d_done_best", n), int'(o_best), exp_best);
                chk($sformatf("r%0d_done_go", n), int'(o_go), 0);
                chk($sformatf("r%0d_done_win", n), int'(o_win), (n == 4) ? 1 : 0);
                if (n < 4) begin
                    exp_seq[n] = model_tile();
                    check_playback(n + 1);
                end
            end
        end
    endtask

    task automatic check_all_zero(input string name);
        chk({name, "_show_on"}, int'(o_so), 0);
        chk({name, "_tile"}, int'(o_tile), 0);
        chk({name, "_await"}, int'(o_aw), 0);
        chk({name, "_score"}, int'(o_score), 0);
        chk({name, "_best"}, int'(o_best), 0);
        chk({name, "_go"}, int'(o_go), 0);
        chk({name, "_win"}, int'(o_win), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at time %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        // rst st kv kt | so ctile tile aw ; first tile from SEED stepped once = 0x59C3 -> 3
        vt[0]  = '{1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 1'b1, 2'd0, 1'b0};
        vt[1]  = '{1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 1'b1, 2'd0, 1'b0};
        vt[2]  = '{1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 2'd0, 1'b0};
        vt[3]  = '{1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 2'd0, 1'b0};
        vt[4]  = '{1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 2'd0, 1'b0};
        vt[5]  = '{1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 1'b1, 2'd3, 1'b0};
        vt[6]  = '{1'b0, 1'b0, 1'b1, 2'd1, 1'b1, 1'b1, 2'd3, 1'b0};
        vt[7]  = '{1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 1'b1, 2'd3, 1'b0};
        vt[8]  = '{1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 2'd0, 1'b0};
        vt[9]  = '{1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 2'd0, 1'b0};
        vt[10] = '{1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 2'd0, 1'b1};

        for (int i = 0; i < 11; i++) begin
            reset       = vt[i].rst;
            start_a     = vt[i].st;
            key_valid_a = vt[i].kv;
            key_tile_a  = vt[i].kt;
            tick();
            chk($sformatf("vec%0d_show_on", i), int'(show_on_a), int'(vt[i].so));
            chk($sformatf("vec%0d_await", i), int'(await_a), int'(vt[i].aw));
            chk($sformatf("vec%0d_score", i), int'(score_a), 0);
            chk($sformatf("vec%0d_best", i), int'(best_a), 0);
            chk($sformatf("vec%0d_go", i), int'(go_a), 0);
            chk($sformatf("vec%0d_win", i), int'(win_a), 0);
            if (vt[i].ctile)
                chk($sformatf("vec%0d_tile", i), int'(show_tile_a), int'(vt[i].tile));
        end
        start_a     = 1'b0;
        key_valid_a = 1'b0;
        exp_seq[0]  = 2'd3;

        // Rounds 1-2 echoed; start accompanying the last key of round 2 is ignored.
        echo_round(1, 1, 1'b0);
        echo_round(2, 1, 1'b1);

        // Round 3: wrong first key loses, score holds at 2.
        tick();
        press(exp_seq[0] ^ 2'd1);
        chk("lose_go", int'(o_go), 1);
        chk("lose_await", int'(o_aw), 0);
        chk("lose_score", int'(o_score), 2);
        chk("lose_best", int'(o_best), 2);
        chk("lose_win", int'(o_win), 0);
        for (int i = 0; i < 3; i++) tick();
        press(exp_seq[0]);
        tick();
        chk("lose_key_ignored_go", int'(o_go), 1);
        chk("lose_key_ignored_await", int'(o_aw), 0);
        chk("lose_key_ignored_score", int'(o_score), 2);
        chk("lose_key_ignored_show", int'(o_so), 0);

        // New game from LOSE, played through to a win.
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        chk("restart_go", int'(o_go), 0);
        chk("restart_score", int'(o_score), 0);
        chk("restart_best", int'(o_best), 2);
        exp_seq[0] = model_tile();
        check_playback(1);
        for (int n = 1; n <= 4; n++) echo_round(n, 1, 1'b0);
        tick();
        press(2'd0);
        chk("win_key_ignored_win", int'(o_win), 1);
        chk("win_key_ignored_score", int'(o_score), 4);
        chk("win_key_ignored_await", int'(o_aw), 0);

        // Start from WIN keeps best score; then reset mid-flash.
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        chk("win_restart_win", int'(o_win), 0);
        chk("win_restart_score", int'(o_score), 0);
        chk("win_restart_best", int'(o_best), 4);
        tick();
        tick();
        tick();
        chk("pre_reset_show_on", int'(o_so), 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        exp_best = 0;
        check_all_zero("mid_reset");
        for (int i = 0; i < 5; i++) tick();
        check_all_zero("idle_after_reset");

        // Timeout instance: no key loses exactly 10 cycles after await rises.
        dsel    = 1'b1;
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        exp_seq[0] = model_tile();
        check_playback(1);
        for (int i = 1; i <= 10; i++) begin
            tick();
            chk($sformatf("to_c%0d_go", i), int'(o_go), (i == 10) ? 1 : 0);
            chk($sformatf("to_c%0d_await", i), int'(o_aw), (i == 10) ? 0 : 1);
        end
        chk("to_score", int'(o_score), 0);

        // Keys every 8 cycles never time out.
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        chk("to_restart_go", int'(o_go), 0);
        exp_seq[0] = model_tile();
        check_playback(1);
        echo_round(1, 7, 1'b0);
        echo_round(2, 7, 1'b0);
        chk("to_slow_keys_best", int'(o_best), 2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
